miriscv_lsu: RTL and testbench
==============================

Name: miriscv_lsu

Overview:
Load/store unit on the core side of the data-memory interface; the initiator for the data port of the instruction/data RAM. Takes a load/store request from the decoder/datapath, checks alignment, and builds byte enables and lane-replicated write data. Drives one memory access, then sign/zero-extends load data and stalls the core until the result is valid.

Parameters:
MEM_WAIT, 0, extra wait cycles held in ACCESS before sampling read data (0..15). Allows slower memories behind the same port.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, synchronous, active-low
lsu_req_i  input  1  core requests a load/store this instruction
lsu_we_i  input  1  1 = store, 0 = load
lsu_size_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  input  32  byte address from ALU
lsu_data_i  input  32  store data (rs2)
lsu_data_o  output  32  extended load result
lsu_stall_req_o  output  1  core must hold PC/pipeline
lsu_err_o  output  1  misaligned or illegal size, one-cycle pulse
data_req_o  output  1  memory request
data_we_o  output  1  memory write enable
data_be_o  output  4  byte enables
data_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
data_wdata_o  output  32  lane-replicated write data
data_rdata_i  input  32  memory read data, combinational response valid while data_req_o=1 and data_we_o=0

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-low via rst_n_i. Reset forces IDLE, wait counter 0, and all outputs 0 (lsu_data_o, data_addr_o, data_wdata_o included). Reset mid-access abandons the access; no write occurs after the reset edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, lsu_req_i=0: all memory-side strobes 0, stall 0.
- IDLE, lsu_req_i=1, legal and aligned:
  - lsu_stall_req_o=1 combinationally.
  - Capture addr, we, size, be, replicated wdata into registers.
  - Go to ACCESS, counter=MEM_WAIT.
- IDLE, lsu_req_i=1, illegal:
  - Illegal means: size 011/110/111; store size 1xx; H/HU with addr[0]=1; W with addr[1:0]≠0.
  - lsu_err_o=1 for that cycle; stall 0; no memory request; stay IDLE.
- ACCESS:
  - data_req_o=1; data_we_o, data_be_o, data_addr_o, data_wdata_o from registers; stall 1.
  - If counter≠0, decrement and stay.
  - If counter=0 and load, register the extended rdata into lsu_data_o; go to DONE.
  - Stores complete on the same counter=0 edge (memory writes that edge).
- DONE: stall 0; data_req_o=0, data_be_o=0; lsu_data_o valid; go to IDLE unconditionally. A lsu_req_i still high in DONE is the same instruction and is not relaunched.
- Latency: stall high for 2+MEM_WAIT cycles; result visible in cycle 2+MEM_WAIT after the request.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Write data:
  - SB: {4{d[7:0]}}.
  - SH: {2{d[15:0]}}.
  - SW: d.
- Load extraction:
  - Lane = rdata>>(8*addr[1:0]).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Outside ACCESS: data_req_o, data_we_o, data_be_o are 0; data_addr_o and data_wdata_o hold their last values.
- lsu_data_o holds its value until the next completed load.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10: data_be_o=1111 during ACCESS; stall 2 cycles each; lsu_data_o=0xDEADBEEF in DONE.
- SB 0xA5 @0x13: data_be_o=1000, data_wdata_o=0xA5A5A5A5. Then LB @0x13 → 0xFFFFFFA5; LBU @0x13 → 0x000000A5.
- SH 0x8001 @0x12: data_be_o=1100. Then LH @0x12 → 0xFFFF8001; LHU → 0x00008001.
- LH @0x11, SW @0x12, size 011: lsu_err_o one-cycle pulse each; data_req_o never 1; stall 0; FSM stays IDLE.
- MEM_WAIT=2, LW: data_req_o high 3 cycles; stall high 4 cycles; data sampled on the last ACCESS edge.
- rst_n_i=0 during ACCESS of SW @0x20: next cycle all outputs 0, IDLE; a subsequent LW @0x20 returns the pre-store contents.

Source files
------------

// File: rtl/miriscv_lsu.sv
// Load/store unit: validates a core load/store, drives one data-memory access,
// then returns the sign/zero-extended load result while stalling the core.
module miriscv_lsu #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_illegal;
  logic        w_start;
  logic        w_access;

  function automatic logic is_illegal(input logic we, input logic [2:0] size,
                                      input logic [1:0] off);
    logic bad;
    case (size)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    return bad | (we & size[2]);
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] size, input logic [31:0] d);
    case (size[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic signed [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  assign w_illegal = is_illegal(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
  assign w_start   = (r_state == S_IDLE) && lsu_req_i && !w_illegal;
  assign w_access  = (r_state == S_ACCESS);

  // Stall asserts in the request cycle itself so the core holds the instruction.
  assign lsu_stall_req_o = w_start || w_access;
  assign lsu_err_o       = (r_state == S_IDLE) && lsu_req_i && w_illegal;
  assign data_req_o      = w_access;
  assign data_we_o       = w_access && r_we;
  assign data_be_o       = w_access ? r_be : 4'b0000;
  assign data_addr_o     = {r_addr[31:2], 2'b00};
  assign data_wdata_o    = r_wdata;
  assign lsu_data_o      = r_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_be    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we    <= lsu_we_i;
            r_size  <= lsu_size_i;
            r_be    <= calc_be(lsu_size_i, lsu_addr_i[1:0]);
            r_addr  <= lsu_addr_i;
            r_wdata <= replicate(lsu_size_i, lsu_data_i);
            r_cnt   <= WAIT_INIT;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_we) r_rdata <= load_extend(r_size, r_addr[1:0], data_rdata_i);
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: a zero-wait instance and a two-wait instance,
// each backed by a small byte-enabled memory model.
module tb_miriscv_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req0, we0;
  logic [2:0]  size0;
  logic [31:0] addr0, wd0;
  logic [31:0] ldata0, daddr0, dwdata0, rdata0;
  logic        stall0, err0, dreq0, dwe0;
  logic [3:0]  dbe0;

  logic        req2, we2;
  logic [2:0]  size2;
  logic [31:0] addr2, wd2;
  logic [31:0] ldata2, daddr2, dwdata2, rdata2;
  logic        stall2, err2, dreq2, dwe2;
  logic [3:0]  dbe2;

  int errors = 0;
  int checks = 0;

  miriscv_lsu #(.MEM_WAIT(0)) u_lsu0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .lsu_req_i(req0), .lsu_we_i(we0), .lsu_size_i(size0),
    .lsu_addr_i(addr0), .lsu_data_i(wd0),
    .lsu_data_o(ldata0), .lsu_stall_req_o(stall0), .lsu_err_o(err0),
    .data_req_o(dreq0), .data_we_o(dwe0), .data_be_o(dbe0),
    .data_addr_o(daddr0), .data_wdata_o(dwdata0), .data_rdata_i(rdata0)
  );

  miriscv_lsu #(.MEM_WAIT(2)) u_lsu2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .lsu_req_i(req2), .lsu_we_i(we2), .lsu_size_i(size2),
    .lsu_addr_i(addr2), .lsu_data_i(wd2),
    .lsu_data_o(ldata2), .lsu_stall_req_o(stall2), .lsu_err_o(err2),
    .data_req_o(dreq2), .data_we_o(dwe2), .data_be_o(dbe2),
    .data_addr_o(daddr2), .data_wdata_o(dwdata2), .data_rdata_i(rdata2)
  );

  // Zero-wait memory: combinational read, byte-enabled write on each request edge.
  logic [31:0] mem0 [0:15];
  assign rdata0 = mem0[daddr0[5:2]];
  always @(posedge clk) begin
    if (dreq0 && dwe0)
      for (int b = 0; b < 4; b++)
        if (dbe0[b]) mem0[daddr0[5:2]][8*b +: 8] <= dwdata0[8*b +: 8];
  end

  // Slow memory: ready only on the third request cycle; read data is zero before that.
  logic [31:0] mem2 [0:15];
  logic [1:0]  mcnt = 2'd0;
  assign rdata2 = (dreq2 && mcnt == 2'd2) ? mem2[daddr2[5:2]] : 32'h0;
  always @(posedge clk) begin
    if (dreq2) begin
      if (dwe2 && mcnt == 2'd2)
        for (int b = 0; b < 4; b++)
          if (dbe2[b]) mem2[daddr2[5:2]][8*b +: 8] <= dwdata2[8*b +: 8];
      mcnt <= mcnt + 2'd1;
    end else begin
      mcnt <= 2'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input string tag, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input logic [31:0] exp_ld);
    req0 = 1'b1; we0 = we; size0 = size; addr0 = addr; wd0 = data;
    #1;
    chk({tag, ".req_stall"}, 32'(stall0), 32'd1);
    chk({tag, ".req_dreq"},  32'(dreq0),  32'd0);
    tick(); #1;
    chk({tag, ".acc_dreq"},  32'(dreq0), 32'd1);
    chk({tag, ".acc_we"},    32'(dwe0),  32'(we));
    chk({tag, ".acc_be"},    32'(dbe0),  32'(exp_be));
    chk({tag, ".acc_addr"},  daddr0,     {addr[31:2], 2'b00});
    if (we) chk({tag, ".acc_wdata"}, dwdata0, exp_wd);
    chk({tag, ".acc_stall"}, 32'(stall0), 32'd1);
    tick(); #1;
    chk({tag, ".done_stall"}, 32'(stall0), 32'd0);
    chk({tag, ".done_dreq"},  32'(dreq0),  32'd0);
    chk({tag, ".done_be"},    32'(dbe0),   32'd0);
    if (!we) chk({tag, ".done_data"}, ldata0, exp_ld);
    req0 = 1'b0;
    tick();
  endtask

  task automatic err0_op(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr);
    req0 = 1'b1; we0 = we; size0 = size; addr0 = addr; wd0 = 32'h1234_5678;
    #1;
    chk({tag, ".err"},   32'(err0),   32'd1);
    chk({tag, ".stall"}, 32'(stall0), 32'd0);
    chk({tag, ".dreq"},  32'(dreq0),  32'd0);
    tick();
    req0 = 1'b0;
    #1;
    chk({tag, ".err_pulse"}, 32'(err0),  32'd0);
    chk({tag, ".idle_dreq"}, 32'(dreq0), 32'd0);
    tick();
  endtask

  task automatic op2(input string tag, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_ld);
    req2 = 1'b1; we2 = we; size2 = size; addr2 = addr; wd2 = data;
    #1;
    chk({tag, ".req_stall"}, 32'(stall2), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk({tag, ".acc_dreq"},  32'(dreq2),  32'd1);
      chk({tag, ".acc_stall"}, 32'(stall2), 32'd1);
    end
    tick(); #1;
    chk({tag, ".done_dreq"},  32'(dreq2),  32'd0);
    chk({tag, ".done_stall"}, 32'(stall2), 32'd0);
    if (!we) chk({tag, ".done_data"}, ldata2, exp_ld);
    req2 = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; size0 = 3'd0; addr0 = 32'd0; wd0 = 32'd0;
    req2 = 1'b0; we2 = 1'b0; size2 = 3'd0; addr2 = 32'd0; wd2 = 32'd0;
    repeat (3) tick();
    chk("rst.ldata0", ldata0,  32'd0);
    chk("rst.stall0", 32'(stall0), 32'd0);
    chk("rst.dreq0",  32'(dreq0),  32'd0);
    chk("rst.be0",    32'(dbe0),   32'd0);
    chk("rst.addr0",  daddr0,  32'd0);
    chk("rst.wdata0", dwdata0, 32'd0);
    chk("rst.ldata2", ldata2,  32'd0);
    rst_n = 1'b1;
    tick();

    op0("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    op0("lw",  1'b0, 3'b010, 32'h10, 32'h0,        4'b1111, 32'h0,        32'hDEADBEEF);
    op0("sb",  1'b1, 3'b000, 32'h13, 32'h123456A5, 4'b1000, 32'hA5A5A5A5, 32'h0);
    op0("lb",  1'b0, 3'b000, 32'h13, 32'h0,        4'b1000, 32'h0,        32'hFFFFFFA5);
    op0("lbu", 1'b0, 3'b100, 32'h13, 32'h0,        4'b1000, 32'h0,        32'h000000A5);
    op0("sh",  1'b1, 3'b001, 32'h12, 32'hFFFF8001, 4'b1100, 32'h80018001, 32'h0);
    op0("lh",  1'b0, 3'b001, 32'h12, 32'h0,        4'b1100, 32'h0,        32'hFFFF8001);
    op0("lhu", 1'b0, 3'b101, 32'h12, 32'h0,        4'b1100, 32'h0,        32'h00008001);
    op0("lb0", 1'b0, 3'b000, 32'h10, 32'h0,        4'b0001, 32'h0,        32'hFFFFFFEF);
    op0("lbu1",1'b0, 3'b100, 32'h11, 32'h0,        4'b0010, 32'h0,        32'h000000BE);
    op0("lh0", 1'b0, 3'b001, 32'h10, 32'h0,        4'b0011, 32'h0,        32'hFFFFBEEF);

    err0_op("lh_mis",   1'b0, 3'b001, 32'h11);
    err0_op("sw_mis",   1'b1, 3'b010, 32'h12);
    err0_op("size011",  1'b0, 3'b011, 32'h10);
    err0_op("sbu",      1'b1, 3'b100, 32'h10);
    chk("err.hold_addr", daddr0, 32'h10);
    chk("err.hold_data", ldata0, 32'hFFFFBEEF);

    op2("sw_w2", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0);
    op2("lw_w2", 1'b0, 3'b010, 32'h20, 32'h0,        32'h11223344);

    // Reset during the first wait cycle of a store must leave memory untouched.
    req2 = 1'b1; we2 = 1'b1; size2 = 3'b010; addr2 = 32'h20; wd2 = 32'h55667788;
    #1;
    chk("rsw.req_stall", 32'(stall2), 32'd1);
    tick();
    rst_n = 1'b0;
    req2 = 1'b0;
    tick(); #1;
    chk("rsw.ldata", ldata2,  32'd0);
    chk("rsw.stall", 32'(stall2), 32'd0);
    chk("rsw.err",   32'(err2),   32'd0);
    chk("rsw.dreq",  32'(dreq2),  32'd0);
    chk("rsw.we",    32'(dwe2),   32'd0);
    chk("rsw.be",    32'(dbe2),   32'd0);
    chk("rsw.addr",  daddr2,  32'd0);
    chk("rsw.wdata", dwdata2, 32'd0);
    rst_n = 1'b1;
    tick();
    op2("lw_after_rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
